// File: rtl/axi_pkg.sv
// ---------------------------------------------------------------------------
// axi_pkg
// Shared AXI-lite definitions for the memory-side interconnect:
//   - AXI response codes
//   - read-arbiter FSM state encoding
//   - master identifiers used as the arbiter's owner / last-grant bit
// ---------------------------------------------------------------------------
package axi_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_AR   = 2'd1,
        ARB_R    = 2'd2
    } arb_state_e;

    localparam logic MST_IFU = 1'b0;
    localparam logic MST_LSU = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-requester round-robin picker.
//   clk, rst    : clock / synchronous active-low reset
//   req[1:0]    : request vector, bit 0 = IFU, bit 1 = LSU
//   update_en   : record update_id as the most recent grant
//   update_id   : master that has just been granted
//   grant_id    : combinational pick for the current request vector
// After reset the last grant is the IFU, so the LSU wins the first tie.
// ---------------------------------------------------------------------------
module rr_arbiter2
    import axi_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update_en,
    input  logic       update_id,
    output logic       grant_id
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        last_grant_d = last_grant_q;
        if (update_en) begin
            last_grant_d = update_id;
        end
    end

    // Tie goes to whoever did not win last; a lone requester always wins.
    always_comb begin
        grant_id = MST_IFU;
        if (req == 2'b11) begin
            grant_id = ~last_grant_q;
        end else if (req[1]) begin
            grant_id = MST_LSU;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant_q <= MST_IFU;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/axi_lite_rd_arbiter.sv
// ---------------------------------------------------------------------------
// axi_lite_rd_arbiter
// Serialises IFU and LSU AXI-lite reads onto the single RAM read port.
// One transaction is outstanding at a time; ties alternate round-robin.
//   clk, rst               : clock / synchronous active-low reset
//   ifu_ar*, ifu_r*        : IFU read address / data channels
//   lsu_ar*, lsu_r*        : LSU read address / data channels
//   ram_ar*, ram_r*        : RAM read address / data channels
//   busy                   : high whenever the FSM is not idle
// All forwarding is combinational from state/owner; the arbiter never
// latches address or data.
// ---------------------------------------------------------------------------
module axi_lite_rd_arbiter
    import axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_arvalid,
    input  logic [ADDR_W-1:0] ifu_araddr,
    output logic              ifu_arready,
    output logic              ifu_rvalid,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic [1:0]        ifu_rresp,
    input  logic              ifu_rready,
    input  logic              lsu_arvalid,
    input  logic [ADDR_W-1:0] lsu_araddr,
    output logic              lsu_arready,
    output logic              lsu_rvalid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic [1:0]        lsu_rresp,
    input  logic              lsu_rready,
    output logic              ram_arvalid,
    output logic [ADDR_W-1:0] ram_araddr,
    input  logic              ram_arready,
    input  logic              ram_rvalid,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic [1:0]        ram_rresp,
    output logic              ram_rready,
    output logic              busy
);

    arb_state_e state_q, state_d;
    logic       owner_q, owner_d;

    logic       grant_id;
    logic       owner_arvalid;
    logic       ar_hs;

    assign owner_arvalid = (owner_q == MST_LSU) ? lsu_arvalid : ifu_arvalid;
    // Address handshake: the only event that records a grant.
    assign ar_hs         = (state_q == ARB_AR) && owner_arvalid && ram_arready;

    rr_arbiter2 u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       ({lsu_arvalid, ifu_arvalid}),
        .update_en (ar_hs),
        .update_id (owner_q),
        .grant_id  (grant_id)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ifu_arready = 1'b0;
        ifu_rvalid  = 1'b0;
        ifu_rdata   = '0;
        ifu_rresp   = AXI_RESP_OKAY;
        lsu_arready = 1'b0;
        lsu_rvalid  = 1'b0;
        lsu_rdata   = '0;
        lsu_rresp   = AXI_RESP_OKAY;
        ram_arvalid = 1'b0;
        ram_araddr  = '0;
        ram_rready  = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                if (ifu_arvalid || lsu_arvalid) begin
                    owner_d = grant_id;
                    state_d = ARB_AR;
                end
            end

            ARB_AR: begin
                ram_arvalid = owner_arvalid;
                if (owner_q == MST_LSU) begin
                    ram_araddr  = lsu_araddr;
                    lsu_arready = ram_arready;
                end else begin
                    ram_araddr  = ifu_araddr;
                    ifu_arready = ram_arready;
                end
                if (ar_hs) begin
                    state_d = ARB_R;
                end else if (!owner_arvalid) begin
                    // Owner withdrew its request: abandon without a grant.
                    state_d = ARB_IDLE;
                end
            end

            ARB_R: begin
                if (owner_q == MST_LSU) begin
                    lsu_rvalid = ram_rvalid;
                    lsu_rdata  = ram_rdata;
                    lsu_rresp  = ram_rresp;
                    ram_rready = lsu_rready;
                end else begin
                    ifu_rvalid = ram_rvalid;
                    ifu_rdata  = ram_rdata;
                    ifu_rresp  = ram_rresp;
                    ram_rready = ifu_rready;
                end
                if (ram_rvalid && ram_rready) begin
                    state_d = ARB_IDLE;
                end
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign busy = (state_q != ARB_IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
            owner_q <= MST_IFU;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // Safety invariants.
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!(ifu_arready && lsu_arready));
            assert (!(ifu_rvalid && lsu_rvalid));
            assert (!ram_arvalid || (state_q == ARB_AR));
            assert (!ram_rready || (state_q == ARB_R));
        end
    end

endmodule

// File: tb/tb_axi_lite_rd_arbiter.sv
module tb_axi_lite_rd_arbiter;

    localparam int AW = 32;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
    logic [AW-1:0] ifu_araddr;
    logic [DW-1:0] ifu_rdata;
    logic [1:0]    ifu_rresp;
    logic          lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
    logic [AW-1:0] lsu_araddr;
    logic [DW-1:0] lsu_rdata;
    logic [1:0]    lsu_rresp;
    logic          ram_arvalid, ram_arready, ram_rvalid, ram_rready;
    logic [AW-1:0] ram_araddr;
    logic [DW-1:0] ram_rdata;
    logic [1:0]    ram_rresp;
    logic          busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    axi_lite_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arready(ifu_arready),
        .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rready(ifu_rready),
        .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arready(lsu_arready),
        .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rready(lsu_rready),
        .ram_arvalid(ram_arvalid), .ram_araddr(ram_araddr), .ram_arready(ram_arready),
        .ram_rvalid(ram_rvalid), .ram_rdata(ram_rdata), .ram_rresp(ram_rresp), .ram_rready(ram_rready),
        .busy(busy)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // RAM content model used by the random phase: data/resp derived from address.
    function automatic logic [63:0] f_data(input logic [31:0] a);
        return {a ^ 32'h5a5a_0f0f, ~a};
    endfunction

    function automatic logic [1:0] f_resp(input logic [31:0] a);
        return a[3:2];
    endfunction

    task automatic check_all_zero(input string tag);
        check_val({tag, "_ifu_arready"}, ifu_arready, 0);
        check_val({tag, "_ifu_rvalid"}, ifu_rvalid, 0);
        check_val({tag, "_ifu_rdata"}, ifu_rdata, 0);
        check_val({tag, "_ifu_rresp"}, ifu_rresp, 0);
        check_val({tag, "_lsu_arready"}, lsu_arready, 0);
        check_val({tag, "_lsu_rvalid"}, lsu_rvalid, 0);
        check_val({tag, "_lsu_rdata"}, lsu_rdata, 0);
        check_val({tag, "_lsu_rresp"}, lsu_rresp, 0);
        check_val({tag, "_ram_arvalid"}, ram_arvalid, 0);
        check_val({tag, "_ram_araddr"}, ram_araddr, 0);
        check_val({tag, "_ram_rready"}, ram_rready, 0);
        check_val({tag, "_busy"}, busy, 0);
    endtask

    // Reset with busy-looking inputs so the all-zero checks mean something.
    task automatic do_reset();
        rst = 1'b0;
        ifu_arvalid = 1'b1; ifu_araddr = 32'h1111_0000; ifu_rready = 1'b1;
        lsu_arvalid = 1'b1; lsu_araddr = 32'h2222_0000; lsu_rready = 1'b1;
        ram_arready = 1'b1; ram_rvalid = 1'b1; ram_rdata = 64'hdead_beef_cafe_f00d; ram_rresp = 2'b11;
        cyc();
        cyc();
        check_all_zero("reset");
        ifu_arvalid = 1'b0; ifu_araddr = '0;
        lsu_arvalid = 1'b0; lsu_araddr = '0;
        ram_arready = 1'b0; ram_rvalid = 1'b0; ram_rdata = '0; ram_rresp = 2'b00;
        rst = 1'b1;
    endtask

    // Waits for the address phase, checks routing, then completes the AR handshake.
    task automatic ar_phase(input bit lsu, input logic [31:0] addr, input int ar_delay, output int waited);
        waited = 0;
        #1;
        while (!ram_arvalid && waited < 10) begin
            cyc();
            waited++;
            #1;
        end
        if (!ram_arvalid) begin
            check_val("ar_timeout", 0, 1);
            return;
        end
        check_val("ar_addr", ram_araddr, addr);
        check_val("ar_busy", busy, 1);
        repeat (ar_delay) begin
            check_val("ar_wait_arready", lsu ? lsu_arready : ifu_arready, 0);
            cyc();
            check_val("ar_hold_valid", ram_arvalid, 1);
        end
        ram_arready = 1'b1;
        #1;
        check_val("arready_owner", lsu ? lsu_arready : ifu_arready, 1);
        check_val("arready_other", lsu ? ifu_arready : lsu_arready, 0);
        cyc();
        ram_arready = 1'b0;
        if (lsu) lsu_arvalid = 1'b0;
        else     ifu_arvalid = 1'b0;
    endtask

    // Data phase: lat idle cycles, then stall cycles with owner rready low, then completion.
    task automatic r_phase(input bit lsu, input logic [63:0] data, input logic [1:0] resp,
                           input int lat, input int stall);
        repeat (lat) begin
            #1;
            check_val("r_no_early_rvalid", lsu ? lsu_rvalid : ifu_rvalid, 0);
            cyc();
        end
        ram_rvalid = 1'b1; ram_rdata = data; ram_rresp = resp;
        repeat (stall) begin
            if (lsu) lsu_rready = 1'b0;
            else     ifu_rready = 1'b0;
            #1;
            check_val("stall_ram_rready", ram_rready, 0);
            check_val("stall_busy", busy, 1);
            check_val("stall_ifu_arready", ifu_arready, 0);
            check_val("stall_lsu_arready", lsu_arready, 0);
            cyc();
        end
        if (lsu) lsu_rready = 1'b1;
        else     ifu_rready = 1'b1;
        #1;
        check_val("r_valid_owner", lsu ? lsu_rvalid : ifu_rvalid, 1);
        check_val("r_valid_other", lsu ? ifu_rvalid : lsu_rvalid, 0);
        check_val("r_data_owner", lsu ? lsu_rdata : ifu_rdata, data);
        check_val("r_data_other", lsu ? ifu_rdata : lsu_rdata, 0);
        check_val("r_resp_owner", lsu ? lsu_rresp : ifu_rresp, resp);
        check_val("r_ram_rready", ram_rready, 1);
        cyc();
        ram_rvalid = 1'b0; ram_rdata = '0; ram_rresp = 2'b00;
        #1;
        check_val("r_done_busy", busy, 0);
        check_val("r_done_rvalid", lsu ? lsu_rvalid : ifu_rvalid, 0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int            w;
        logic [31:0]   m_addr [2];
        logic [31:0]   m_infl [2];
        bit            m_pend [2];
        int            m_left [2];
        bit            ram_busy;
        logic [31:0]   ram_addr;
        int            ram_cnt;
        bit            exp_next;
        bit            g;
        int            done;
        int            cycles;

        // ---------------- IFU-only read ----------------
        do_reset();
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0000;
        #1;
        check_val("idle_no_arvalid", ram_arvalid, 0);
        ar_phase(0, 32'h8000_0000, 1, w);
        check_val("ifu_arb_latency", w, 1);
        r_phase(0, 64'h0000_0013_0010_0073, 2'b00, 1, 0);

        // ---------------- tie after reset: LSU, IFU, LSU, IFU ----------------
        do_reset();
        for (int round = 0; round < 2; round++) begin
            ifu_arvalid = 1'b1; ifu_araddr = 32'h0000_1000 + 32'(round);
            lsu_arvalid = 1'b1; lsu_araddr = 32'h0000_2000 + 32'(round);
            ar_phase(1, 32'h0000_2000 + 32'(round), 0, w);
            check_val("tie_lsu_latency", w, 1);
            r_phase(1, 64'h2222_0000 + 64'(round), 2'b00, 0, 0);
            ar_phase(0, 32'h0000_1000 + 32'(round), 0, w);
            check_val("b2b_ifu_latency", w, 1);
            r_phase(0, 64'h1111_0000 + 64'(round), 2'b01, 2, 0);
        end

        // ---------------- LSU stall with pending IFU, then IFU error resp ----------------
        lsu_arvalid = 1'b1; lsu_araddr = 32'h0000_3000;
        ar_phase(1, 32'h0000_3000, 0, w);
        ifu_arvalid = 1'b1; ifu_araddr = 32'h0000_4000;
        r_phase(1, 64'h3333_3333_3333_3333, 2'b00, 2, 5);
        ar_phase(0, 32'h0000_4000, 0, w);
        check_val("after_stall_latency", w, 1);
        r_phase(0, 64'h4444_5555_6666_7777, 2'b10, 1, 0);

        // ---------------- reset mid-transaction ----------------
        lsu_arvalid = 1'b1; lsu_araddr = 32'h0000_5000;
        ar_phase(1, 32'h0000_5000, 0, w);
        r_phase(1, 64'h5, 2'b11, 0, 0);
        ifu_arvalid = 1'b1; ifu_araddr = 32'h0000_6000;
        cyc();
        check_val("mid_in_ar", ram_arvalid, 1);
        ram_arready = 1'b1;
        rst = 1'b0;
        cyc();
        check_all_zero("midrst");
        ram_arready = 1'b0;
        rst = 1'b1;
        lsu_arvalid = 1'b1; lsu_araddr = 32'h0000_7000;
        ar_phase(1, 32'h0000_7000, 0, w);
        r_phase(1, 64'h7, 2'b00, 0, 0);
        ar_phase(0, 32'h0000_6000, 0, w);
        r_phase(0, 64'h6, 2'b00, 0, 0);

        // ---------------- random continuous contention ----------------
        do_reset();
        m_pend[0] = 0; m_pend[1] = 0;
        m_left[0] = 10; m_left[1] = 10;
        m_addr[0] = '0; m_addr[1] = '0;
        m_infl[0] = '0; m_infl[1] = '0;
        ram_busy = 0; ram_addr = '0; ram_cnt = 0;
        exp_next = 1'b1;
        done = 0; cycles = 0;
        while (done < 20 && cycles < 3000) begin
            for (int i = 0; i < 2; i++) begin
                if (!m_pend[i] && m_left[i] > 0) begin
                    m_pend[i] = 1'b1;
                    m_addr[i] = $urandom;
                    m_left[i]--;
                end
            end
            ifu_arvalid = m_pend[0]; ifu_araddr = m_pend[0] ? m_addr[0] : '0;
            lsu_arvalid = m_pend[1]; lsu_araddr = m_pend[1] ? m_addr[1] : '0;
            ifu_rready  = ($urandom_range(0, 3) != 0);
            lsu_rready  = ($urandom_range(0, 3) != 0);
            ram_arready = !ram_busy && ($urandom_range(0, 1) == 1);
            ram_rvalid  = ram_busy && (ram_cnt == 0);
            ram_rdata   = ram_rvalid ? f_data(ram_addr) : '0;
            ram_rresp   = ram_rvalid ? f_resp(ram_addr) : 2'b00;
            #1;
            check_val("rand_one_rvalid", ifu_rvalid && lsu_rvalid, 0);
            check_val("rand_one_outstanding", ram_arvalid && ram_busy, 0);
            if (ram_arvalid && ram_arready) begin
                g = lsu_arready;
                check_val("rand_grant_excl", ifu_arready && lsu_arready, 0);
                check_val("rand_grant_any", ifu_arready || lsu_arready, 1);
                check_val("rand_grant_order", g, exp_next);
                check_val("rand_grant_pending", m_pend[g], 1);
                check_val("rand_grant_addr", ram_araddr, m_addr[g]);
                m_pend[g] = 1'b0;
                m_infl[g] = m_addr[g];
                exp_next  = ~g;
                ram_busy  = 1'b1;
                ram_addr  = ram_araddr;
                ram_cnt   = $urandom_range(0, 4);
            end else if (ram_busy && ram_cnt > 0) begin
                ram_cnt--;
            end
            if (ram_rvalid && ram_rready) begin
                g = lsu_rvalid;
                check_val("rand_r_any", ifu_rvalid || lsu_rvalid, 1);
                check_val("rand_r_data", g ? lsu_rdata : ifu_rdata, f_data(m_infl[g]));
                check_val("rand_r_resp", g ? lsu_rresp : ifu_rresp, f_resp(m_infl[g]));
                check_val("rand_r_rready", g ? lsu_rready : ifu_rready, 1);
                ram_busy = 1'b0;
                done++;
            end
            cyc();
            cycles++;
        end
        check_val("rand_all_done", done, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
